// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access size codes,
// FSM state encoding and the alignment rule.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_MRG,
        ST_WR
    } state_t;

    // Size 11 is treated as a misaligned access so both error causes share one path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = byte_off[0];
            SZ_W:    bad = (byte_off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word,
// and builds the merged word for byte/half stores.
module dmem_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  byte_off,
    input  logic [31:0] ram_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    always_comb begin
        byte_lane = ram_word[{byte_off, 3'b000} +: 8];
        half_lane = ram_word[{byte_off[1], 4'b0000} +: 16];
        sign_bit  = 1'b0;
        load_data = ram_word;
        case (size)
            SZ_B: begin
                sign_bit  = ~is_unsigned & byte_lane[7];
                load_data = {{24{sign_bit}}, byte_lane};
            end
            SZ_H: begin
                sign_bit  = ~is_unsigned & half_lane[15];
                load_data = {{16{sign_bit}}, half_lane};
            end
            default: load_data = ram_word;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the word comes from the RAM read.
    always_comb begin
        merge_data = ram_word;
        case (size)
            SZ_B:    merge_data[{byte_off, 3'b000} +: 8] = store_data[7:0];
            SZ_H:    merge_data[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: merge_data = store_data;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a 1-cycle synchronous-read data RAM with a single
// whole-word write enable. Sub-word stores are performed as read-modify-write.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        misaligned;
    logic        start;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_ready  = (state == ST_IDLE);
    assign accept     = req_valid & req_ready;
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign start      = accept & ~misaligned;

    dmem_lane_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .byte_off    (off_q),
        .ram_word    (ram_dout),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Whole-word stores skip the read; everything else reads first.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (req_we && (req_size == SZ_W)) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_RD;
                    end
                end
            end
            ST_RD:   state_next = we_q ? ST_MRG : ST_WAIT;
            ST_WAIT: state_next = ST_IDLE;
            ST_MRG:  state_next = ST_IDLE;
            ST_WR:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM strobes depend on the state register alone, so reset removes them immediately.
    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_din = 32'h0;
        case (state)
            ST_RD: begin
                ram_en = 1'b1;
            end
            ST_MRG: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_din = merge_data;
            end
            ST_WR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_din = wdata_q;
            end
            default: begin
                ram_en  = 1'b0;
                ram_we  = 1'b0;
                ram_din = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            ram_addr   <= '0;
        end else if (start) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            ram_addr   <= req_addr[ADDR_W+1:2];
        end
    end

    // Response is a single-cycle pulse; rdata is non-zero only for completed loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            if (accept && misaligned) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
            end
            case (state)
                ST_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                end
                ST_MRG, ST_WR: begin
                    rsp_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 256x32 synchronous block RAM
// and hand-computed expected values.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [256];

    int vec_cnt = 0;
    int err_cnt = 0;
    int en_cnt  = 0;
    int we_cnt  = 0;

    dmem_lsu #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_en) en_cnt = en_cnt + 1;
        if (ram_we) we_cnt = we_cnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [9:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err,
                                 output int lat, output logic seen);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        en_cnt = 0; we_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        seen  = rsp_valid;
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic doOp(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_en, input int exp_we);
        logic [31:0] rdata;
        logic        err;
        logic        seen;
        int          lat;
        applyStimulus(we, size, uns, addr, wdata, rdata, err, lat, seen);
        checkOutput({tag, "_rsp"},   {31'b0, seen}, 32'h1);
        checkOutput({tag, "_lat"},   lat, exp_lat);
        checkOutput({tag, "_err"},   {31'b0, err}, {31'b0, exp_err});
        checkOutput({tag, "_rdata"}, rdata, exp_rdata);
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, {31'b0, rsp_valid}, 32'h0);
        checkOutput({tag, "_en"},    en_cnt, exp_en);
        checkOutput({tag, "_we"},    we_cnt, exp_we);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 10'h0; req_wdata = 32'h0;

        // Reset state
        #12;
        checkOutput("rst_ram_en",   {31'b0, ram_en}, 32'h0);
        checkOutput("rst_ram_we",   {31'b0, ram_we}, 32'h0);
        checkOutput("rst_rsp_val",  {31'b0, rsp_valid}, 32'h0);
        checkOutput("rst_rdata",    rsp_rdata, 32'h0);
        checkOutput("rst_ram_addr", {24'b0, ram_addr}, 32'h0);
        checkOutput("rst_ram_din",  ram_din, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_ready", {31'b0, req_ready}, 32'h1);

        // Word store and load
        doOp("sw0", 1'b1, 2'b10, 1'b0, 10'h000, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1, 1);
        checkOutput("sw0_mem", mem[0], 32'hDEADBEEF);
        doOp("lw0", 1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

        // Byte store and byte loads
        doOp("sb1", 1'b1, 2'b00, 1'b0, 10'h001, 32'h00000055, 32'h0, 1'b0, 2, 2, 1);
        checkOutput("sb1_mem", mem[0], 32'hDEAD55EF);
        doOp("lb1",  1'b0, 2'b00, 1'b0, 10'h001, 32'h0, 32'h00000055, 1'b0, 2, 1, 0);
        doOp("lb3",  1'b0, 2'b00, 1'b0, 10'h003, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1, 0);
        doOp("lbu3", 1'b0, 2'b00, 1'b1, 10'h003, 32'h0, 32'h000000DE, 1'b0, 2, 1, 0);

        // Half store and half loads
        doOp("sh6", 1'b1, 2'b01, 1'b0, 10'h006, 32'h00008001, 32'h0, 1'b0, 2, 2, 1);
        checkOutput("sh6_mem", mem[1], 32'h80010000);
        doOp("lh6",  1'b0, 2'b01, 1'b0, 10'h006, 32'h0, 32'hFFFF8001, 1'b0, 2, 1, 0);
        doOp("lhu6", 1'b0, 2'b01, 1'b1, 10'h006, 32'h0, 32'h00008001, 1'b0, 2, 1, 0);
        doOp("lh4",  1'b0, 2'b01, 1'b0, 10'h004, 32'h0, 32'h00000000, 1'b0, 2, 1, 0);

        // Misaligned and illegal-size requests
        doOp("lw2",   1'b0, 2'b10, 1'b0, 10'h002, 32'h0, 32'h0, 1'b1, 0, 0, 0);
        doOp("sh3",   1'b1, 2'b01, 1'b0, 10'h003, 32'hFFFF, 32'h0, 1'b1, 0, 0, 0);
        doOp("sz11",  1'b0, 2'b11, 1'b0, 10'h000, 32'h0, 32'h0, 1'b1, 0, 0, 0);
        checkOutput("err_mem0", mem[0], 32'hDEAD55EF);
        checkOutput("err_mem1", mem[1], 32'h80010000);

        // Top of address space
        doOp("swtop", 1'b1, 2'b10, 1'b0, 10'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1, 1);
        checkOutput("swtop_mem", mem[255], 32'hCAFEF00D);
        doOp("lbutop", 1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0, 32'h000000CA, 1'b0, 2, 1, 0);
        doOp("lbtop",  1'b0, 2'b00, 1'b0, 10'h3FE, 32'h0, 32'hFFFFFFFE, 1'b0, 2, 1, 0);

        // Reset asserted during the merge-write cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h000; req_wdata = 32'h00000011;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("mrg_we", {31'b0, ram_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_we",  {31'b0, ram_we}, 32'h0);
        checkOutput("arst_en",  {31'b0, ram_en}, 32'h0);
        checkOutput("arst_rsp", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("arst_norsp", {31'b0, rsp_valid}, 32'h0);
        checkOutput("arst_mem0", mem[0], 32'hDEAD55EF);

        // Back-to-back: load issued in the store's response cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 10'h008;
        req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b_sw_rsp", {31'b0, rsp_valid}, 32'h1);
        checkOutput("b2b_ready",  {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 10'h008; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("b2b_busy", {31'b0, req_ready}, 32'h0);
        checkOutput("b2b_gap",  {31'b0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("b2b_lw_rsp",   {31'b0, rsp_valid}, 32'h1);
        checkOutput("b2b_lw_rdata", rsp_rdata, 32'h12345678);
        checkOutput("b2b_mem2",     mem[2], 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
